// File: rtl/regdump_pkg.sv
// Shared types and defaults for the register-dump serializer.
// The FSM encoding lives here so the top and any future monitors agree on it.
package regdump_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HEADER  = 3'd1,
        ST_LOAD    = 3'd2,
        ST_SEND    = 3'd3,
        ST_TRAILER = 3'd4
    } state_e;

    localparam logic [7:0] HEADER_DEFAULT   = 8'hA5;
    localparam int         NUM_REGS_DEFAULT = 32;
    localparam int         BYTES_PER_REG    = 4;

endpackage

// File: rtl/tx_byte_reg.sv
// Output byte register with valid/ready handshake: a loaded byte is held
// stable until the sink accepts it.
module tx_byte_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         load_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         xfer_o
);

    logic         valid_q, valid_d;
    logic [W-1:0] data_q, data_d;

    assign xfer_o  = valid_q & ready_i;
    assign valid_o = valid_q;
    assign data_o  = data_q;

    // A load in the same cycle as an accept replaces the byte without a bubble.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load_i) begin
            valid_d = 1'b1;
            data_d  = data_i;
        end else if (xfer_o) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

endmodule

// File: rtl/regdump_tx.sv
// Serializes a register file as HEADER, 4 bytes per register (MSB first),
// then an XOR checksum of the data bytes, over a valid/ready byte stream.
module regdump_tx
    import regdump_pkg::*;
#(
    parameter int         NUM_REGS = NUM_REGS_DEFAULT,
    parameter logic [7:0] HEADER   = HEADER_DEFAULT
) (
    input  logic        hz100,
    input  logic        reset,
    input  logic        start,
    output logic [4:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    localparam logic [4:0] LAST_REG  = 5'(NUM_REGS - 1);
    localparam logic [1:0] LAST_BYTE = 2'(BYTES_PER_REG - 1);

    state_e      state_q, state_d;
    logic [4:0]  reg_cnt_q, reg_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [31:0] shift_q, shift_d;
    logic [7:0]  csum_q, csum_d;
    logic        done_q, done_d;

    logic        ld;
    logic [7:0]  ld_data;
    logic        xfer;

    tx_byte_reg #(.W(8)) u_out (
        .clk     (hz100),
        .srst    (reset),
        .load_i  (ld),
        .data_i  (ld_data),
        .ready_i (tx_ready),
        .valid_o (tx_valid),
        .data_o  (tx_data),
        .xfer_o  (xfer)
    );

    always_comb begin
        state_d    = state_q;
        reg_cnt_d  = reg_cnt_q;
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        csum_d     = csum_q;
        done_d     = 1'b0;
        ld         = 1'b0;
        ld_data    = 8'h00;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_HEADER;
                    ld         = 1'b1;
                    ld_data    = HEADER;
                    reg_cnt_d  = '0;
                    byte_cnt_d = '0;
                    csum_d     = '0;
                end
            end
            ST_HEADER: begin
                if (xfer) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // First byte goes straight to the output so SEND starts valid.
                shift_d    = rd_data;
                ld         = 1'b1;
                ld_data    = rd_data[31:24];
                byte_cnt_d = '0;
                state_d    = ST_SEND;
            end
            ST_SEND: begin
                if (xfer) begin
                    csum_d = csum_q ^ tx_data;
                    if (byte_cnt_q != LAST_BYTE) begin
                        byte_cnt_d = byte_cnt_q + 2'd1;
                        shift_d    = {shift_q[23:0], shift_q[31:24]};
                        ld         = 1'b1;
                        ld_data    = shift_q[23:16];
                    end else begin
                        byte_cnt_d = '0;
                        if (reg_cnt_q == LAST_REG) begin
                            state_d = ST_TRAILER;
                            ld      = 1'b1;
                            ld_data = csum_q ^ tx_data;
                        end else begin
                            reg_cnt_d = reg_cnt_q + 5'd1;
                            state_d   = ST_LOAD;
                        end
                    end
                end
            end
            ST_TRAILER: begin
                if (xfer) begin
                    state_d   = ST_IDLE;
                    reg_cnt_d = '0;
                    done_d    = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge hz100) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            reg_cnt_q  <= '0;
            byte_cnt_q <= '0;
            shift_q    <= '0;
            csum_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            reg_cnt_q  <= reg_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
            csum_q     <= csum_d;
            done_q     <= done_d;
        end
    end

    assign rd_addr = reg_cnt_q;
    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;

endmodule

// File: tb/tb_regdump_tx.sv
// Self-checking bench for regdump_tx: table-driven frames, directed corner
// sequences and randomized frames compared against a byte-list reference model.
module tb_regdump_tx;

    localparam int         NREGS     = 32;
    localparam logic [7:0] HDR       = 8'hA5;
    localparam int         FRAME_LEN = 4 * NREGS + 2;

    typedef struct {
        logic [31:0] fill;
        int          idx;
        logic [31:0] val;
        logic [7:0]  trailer;
        int          rmode;
    } vec_t;

    logic        hz100    = 1'b0;
    logic        reset    = 1'b1;
    logic        start    = 1'b0;
    logic        tx_ready = 1'b0;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        busy;
    logic        done;

    logic [31:0] regfile [NREGS];
    assign rd_data = regfile[rd_addr];

    int         checks     = 0;
    int         failures   = 0;
    int         ready_mode = 0;   // 0 tied high, 1 random, 3 driven by the main sequence
    int         done_cnt   = 0;
    logic [7:0] got_q[$];
    bit         stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;
    bit         reset_prev = 1'b1;
    vec_t       vecs[5];

    regdump_tx #(.NUM_REGS(NREGS), .HEADER(HDR)) dut (
        .hz100    (hz100),
        .reset    (reset),
        .start    (start),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .busy     (busy),
        .done     (done)
    );

    always #5 hz100 = ~hz100;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge hz100);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge hz100);
            #1;
            if (ready_mode == 0)
                tx_ready = 1'b1;
            else if (ready_mode == 1)
                tx_ready = 1'($urandom_range(0, 1));
        end
    end

    // Records accepted bytes and checks hold-while-stalled on the falling edge.
    initial begin
        forever begin
            @(negedge hz100);
            if (stall_prev && !reset_prev) begin
                check("hold_valid", {31'd0, tx_valid}, 32'd1);
                check("hold_data", {24'd0, tx_data}, {24'd0, stall_data});
            end
            if (tx_valid && tx_ready && !reset)
                got_q.push_back(tx_data);
            if (tx_valid)
                check("busy_with_valid", {31'd0, busy}, 32'd1);
            if (done) begin
                done_cnt++;
                check("done_busy_low", {31'd0, busy}, 32'd0);
            end
            stall_prev = tx_valid && !tx_ready;
            stall_data = tx_data;
            reset_prev = reset;
        end
    end

    initial begin
        #1_000_000;
        failures++;
        $display("FAIL watchdog got=timeout expected=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Reference: header, every register MSB first, XOR of the data bytes.
    task automatic build_expected(output logic [7:0] q[$]);
        logic [7:0] x;
        logic [7:0] bt;
        logic [31:0] w;
        q = {};
        x = 8'h00;
        q.push_back(HDR);
        for (int r = 0; r < NREGS; r++) begin
            w = regfile[r];
            for (int b = 3; b >= 0; b--) begin
                bt = w[8*b +: 8];
                q.push_back(bt);
                x = x ^ bt;
            end
        end
        q.push_back(x);
    endtask

    task automatic compare_frame(input string tag, input logic [7:0] q[$]);
        logic [7:0] exp_q[$];
        int nerr;
        build_expected(exp_q);
        check({tag, "_len"}, q.size(), FRAME_LEN);
        nerr = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= q.size() || q[i] !== exp_q[i]) nerr++;
        check({tag, "_bad_bytes"}, nerr, 0);
        $display("frame %s bytes=%0d trailer=%02h bad=%0d", tag, q.size(),
                 (q.size() > 0) ? q[q.size()-1] : 8'h00, nerr);
    endtask

    task automatic set_regs(input logic [31:0] fill, input int idx, input logic [31:0] val);
        for (int r = 0; r < NREGS; r++) regfile[r] = fill;
        regfile[idx] = val;
    endtask

    task automatic random_regs();
        for (int r = 0; r < NREGS; r++) regfile[r] = $urandom;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge hz100);
            if (done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_bytes(input int n, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge hz100);
            if (got_q.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
        check("bytes_reached", {31'd0, ok}, 32'd1);
    endtask

    task automatic pulse_start_checked(input string tag);
        start = 1'b1;
        tick();
        start = 1'b0;
        check({tag, "_hdr_valid"}, {31'd0, tx_valid}, 32'd1);
        check({tag, "_hdr_data"}, {24'd0, tx_data}, {24'd0, HDR});
        check({tag, "_busy"}, {31'd0, busy}, 32'd1);
    endtask

    task automatic pulse_start_raw();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, {31'd0, tx_valid}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_rd_addr"}, {27'd0, rd_addr}, 32'd0);
        check({tag, "_tx_data"}, {24'd0, tx_data}, 32'd0);
    endtask

    initial begin
        int d0;
        bit ok;
        int sz;
        int ndiff;
        logic [7:0] last;
        logic [7:0] first_q[$];

        vecs[0] = '{32'h0000_0000, 5,  32'h1234_5678, 8'h08, 0};
        vecs[1] = '{32'hDEAD_BEEF, 0,  32'hDEAD_BEEF, 8'h00, 1};
        vecs[2] = '{32'h0000_0000, 31, 32'hFF00_0000, 8'hFF, 0};
        vecs[3] = '{32'h0101_0101, 0,  32'h0101_0100, 8'h01, 1};
        vecs[4] = '{32'h0000_0000, 0,  32'h8040_2010, 8'hF0, 0};
        set_regs(32'h0, 0, 32'h0);

        // Reset held three cycles
        reset = 1'b1;
        repeat (3) tick();
        check_reset_outputs("rst");
        reset = 1'b0;
        tick();

        // Table-driven frames
        for (int v = 0; v < 5; v++) begin
            set_regs(vecs[v].fill, vecs[v].idx, vecs[v].val);
            ready_mode = vecs[v].rmode;
            tick();
            got_q.delete();
            d0 = done_cnt;
            pulse_start_checked($sformatf("vec%0d", v));
            wait_done(3000, ok);
            check("vec_done_seen", {31'd0, ok}, 32'd1);
            repeat (3) tick();
            check("vec_done_count", done_cnt - d0, 32'd1);
            last = 8'hxx;
            if (got_q.size() > 0) last = got_q[got_q.size()-1];
            check("vec_trailer", {24'd0, last}, {24'd0, vecs[v].trailer});
            compare_frame($sformatf("vec%0d", v), got_q);
        end

        // Backpressure: ten stalled cycles mid-register, then random ready
        set_regs(32'hDEAD_BEEF, 0, 32'hDEAD_BEEF);
        ready_mode = 0;
        tick();
        got_q.delete();
        d0 = done_cnt;
        pulse_start_checked("bp");
        wait_bytes(6, 200);
        tick();
        ready_mode = 3;
        tx_ready = 1'b0;
        sz = got_q.size();
        repeat (10) tick();
        check("bp_stall_no_xfer", got_q.size(), sz);
        check("bp_stall_valid", {31'd0, tx_valid}, 32'd1);
        ready_mode = 1;
        wait_done(3000, ok);
        check("bp_done_seen", {31'd0, ok}, 32'd1);
        repeat (3) tick();
        check("bp_done_count", done_cnt - d0, 32'd1);
        compare_frame("bp", got_q);

        // Start pulses while busy must not spawn another frame
        random_regs();
        ready_mode = 0;
        tick();
        got_q.delete();
        d0 = done_cnt;
        pulse_start_checked("sb");
        wait_bytes(3, 100);
        pulse_start_raw();
        wait_bytes(60, 200);
        pulse_start_raw();
        wait_done(3000, ok);
        check("sb_done_seen", {31'd0, ok}, 32'd1);
        repeat (20) tick();
        check("sb_done_count", done_cnt - d0, 32'd1);
        check("sb_idle_busy", {31'd0, busy}, 32'd0);
        check("sb_idle_valid", {31'd0, tx_valid}, 32'd0);
        compare_frame("sb", got_q);

        // Reset mid-frame, with start held during reset
        random_regs();
        ready_mode = 0;
        tick();
        got_q.delete();
        pulse_start_checked("mr");
        wait_bytes(40, 200);
        d0 = done_cnt;
        reset = 1'b1;
        start = 1'b1;
        tick();
        check_reset_outputs("mr_rst");
        tick();
        check("mr_start_in_reset", {31'd0, busy}, 32'd0);
        reset = 1'b0;
        start = 1'b0;
        repeat (20) tick();
        check("mr_no_done", done_cnt - d0, 32'd0);
        check("mr_idle_valid", {31'd0, tx_valid}, 32'd0);
        got_q.delete();
        d0 = done_cnt;
        pulse_start_checked("mr2");
        wait_done(3000, ok);
        check("mr2_done_seen", {31'd0, ok}, 32'd1);
        repeat (3) tick();
        check("mr2_done_count", done_cnt - d0, 32'd1);
        compare_frame("mr2", got_q);

        // Back-to-back: start asserted in the done cycle
        random_regs();
        ready_mode = 1;
        tick();
        got_q.delete();
        d0 = done_cnt;
        pulse_start_checked("b2b1");
        wait_done(3000, ok);
        check("b2b1_done_seen", {31'd0, ok}, 32'd1);
        first_q = got_q;
        got_q.delete();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("b2b2_hdr_valid", {31'd0, tx_valid}, 32'd1);
        check("b2b2_hdr_data", {24'd0, tx_data}, {24'd0, HDR});
        wait_done(3000, ok);
        check("b2b2_done_seen", {31'd0, ok}, 32'd1);
        repeat (3) tick();
        check("b2b_done_count", done_cnt - d0, 32'd2);
        compare_frame("b2b1", first_q);
        compare_frame("b2b2", got_q);
        ndiff = 0;
        for (int i = 0; i < first_q.size(); i++)
            if (i >= got_q.size() || got_q[i] !== first_q[i]) ndiff++;
        check("b2b_same_frame", ndiff, 0);

        // Randomized frames against the reference model
        for (int k = 0; k < 3; k++) begin
            random_regs();
            ready_mode = 1;
            tick();
            got_q.delete();
            d0 = done_cnt;
            pulse_start_checked($sformatf("rnd%0d", k));
            wait_done(3000, ok);
            check("rnd_done_seen", {31'd0, ok}, 32'd1);
            repeat (3) tick();
            check("rnd_done_count", done_cnt - d0, 32'd1);
            compare_frame($sformatf("rnd%0d", k), got_q);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
